// File: rtl/fast_kp_sched.sv
// fast_kp_sched: issue scheduler and keypoint collector for the FAST-9 corner
// datapath. Windows are admitted under a credit rule, tagged through a shadow
// pipeline that tracks the fixed datapath latency, and flagged results are
// queued in a keypoint FIFO with a registered head.
// Optional feature macro: FAST_KP_CAP_EN (per-frame keypoint cap of MAX_KP).
module fast_kp_sched #(
  parameter int LATENCY = 6,
  parameter int DEPTH   = 8,
  parameter int COORD_W = 10,
  parameter int MAX_KP  = 1023
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_win_valid,
  output logic               o_win_ready,
  input  logic [COORD_W-1:0] i_win_x,
  input  logic [COORD_W-1:0] i_win_y,
  input  logic               i_win_last,
  input  logic               i_dp_flag,
  input  logic [7:0]         i_dp_score,
  output logic               o_kp_valid,
  input  logic               i_kp_ready,
  output logic [COORD_W-1:0] o_kp_x,
  output logic [COORD_W-1:0] o_kp_y,
  output logic [7:0]         o_kp_score,
  output logic               o_frame_done,
  output logic [10:0]        o_kp_count,
  output logic               o_kp_drop
);

`ifdef FAST_KP_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + LATENCY + 1);
  localparam int ENT_W = 2 * COORD_W + 8;
  localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W + 1)'(DEPTH);
  localparam logic [10:0]    KP_CAP     = 11'(MAX_KP);
  localparam logic [10:0]    KP_SAT     = 11'h7FF;

  // Shadow pipeline storage, one entry per datapath stage
  logic               sh_valid_reg [LATENCY];
  logic               sh_last_reg  [LATENCY];
  logic [COORD_W-1:0] sh_x_reg     [LATENCY];
  logic [COORD_W-1:0] sh_y_reg     [LATENCY];
  logic               sh_valid_next[LATENCY];
  logic               sh_last_next [LATENCY];
  logic [COORD_W-1:0] sh_x_next    [LATENCY];
  logic [COORD_W-1:0] sh_y_next    [LATENCY];

  // Credit / FIFO / frame bookkeeping
  logic [CNT_W-1:0] inflight_reg;
  logic [CNT_W-1:0] fifo_count_reg;
  logic [CNT_W-1:0] fifo_count_next;
  logic [CNT_W:0]   credit_used;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] head_reg;
  logic [ENT_W-1:0] push_data;
  logic [10:0]      kp_count_reg;
  logic [10:0]      kp_count_next;
  logic             kp_drop_reg;
  logic             kp_drop_next;

  logic accept;
  logic exit_valid;
  logic exit_flag;
  logic under_cap;
  logic push;
  logic pop;
  logic drop_evt;
  logic frame_done;

  // Every in-flight window is counted as a future keypoint, so the FIFO
  // can never be asked to take more than it holds.
  assign credit_used = {1'b0, fifo_count_reg} + {1'b0, inflight_reg};
  assign o_win_ready = ~i_rst & (credit_used < CREDIT_LIM);
  assign accept      = i_win_valid & o_win_ready;

  // Stage 0 samples the window fields every cycle; only the valid bit
  // decides whether the slot carries a real tag.
  assign sh_valid_next[0] = accept;
  assign sh_last_next[0]  = i_win_last;
  assign sh_x_next[0]     = i_win_x;
  assign sh_y_next[0]     = i_win_y;

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_shift
      assign sh_valid_next[gi] = sh_valid_reg[gi-1];
      assign sh_last_next[gi]  = sh_last_reg[gi-1];
      assign sh_x_next[gi]     = sh_x_reg[gi-1];
      assign sh_y_next[gi]     = sh_y_reg[gi-1];
    end
  endgenerate

  // Shadow pipeline advances unconditionally, in lockstep with the datapath
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LATENCY; i++) begin
      if (i_rst) begin
        sh_valid_reg[i] <= 1'b0;
        sh_last_reg[i]  <= 1'b0;
        sh_x_reg[i]     <= '0;
        sh_y_reg[i]     <= '0;
      end else begin
        sh_valid_reg[i] <= sh_valid_next[i];
        sh_last_reg[i]  <= sh_last_next[i];
        sh_x_reg[i]     <= sh_x_next[i];
        sh_y_reg[i]     <= sh_y_next[i];
      end
    end
  end

  // Exit stage: the datapath result lines up with the oldest tag
  assign exit_valid = sh_valid_reg[LATENCY-1];
  assign frame_done = exit_valid & sh_last_reg[LATENCY-1];
  assign exit_flag  = exit_valid & i_dp_flag;
  assign under_cap  = !CAP_EN || (kp_count_reg < KP_CAP);
  assign push       = exit_flag & under_cap;
  assign drop_evt   = exit_flag & ~under_cap;
  assign push_data  = {sh_x_reg[LATENCY-1], sh_y_reg[LATENCY-1], i_dp_score};

  // In-flight tag count: +1 per accept, -1 per tag leaving the exit stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_reg + CNT_W'(accept) - CNT_W'(exit_valid);
    end
  end

  assign o_kp_valid      = (fifo_count_reg != '0);
  assign pop             = o_kp_valid & i_kp_ready;
  assign rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);
  assign fifo_count_next = fifo_count_reg + CNT_W'(push) - CNT_W'(pop);

  // Keypoint storage array (no reset; contents are qualified by the count)
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_reg + PTR_W'(push);
      rd_ptr_reg     <= rd_ptr_next;
      fifo_count_reg <= fifo_count_next;
    end
  end

  // Registered head: reads the next head slot, bypassing a same-cycle write
  // into that slot (empty FIFO, or last entry popped while a new one lands)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_reg <= '0;
    end else if (fifo_count_next != '0) begin
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
        head_reg <= push_data;
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign o_kp_x     = head_reg[ENT_W-1 -: COORD_W];
  assign o_kp_y     = head_reg[8 +: COORD_W];
  assign o_kp_score = head_reg[7:0];

  // Per-frame keypoint count and drop flag; a frame end restarts both, with
  // a push in the same cycle counted into the new value
  always_comb begin
    kp_count_next = kp_count_reg;
    kp_drop_next  = kp_drop_reg;
    if (frame_done) begin
      kp_count_next = {10'd0, push};
      kp_drop_next  = drop_evt;
    end else begin
      if (push && (kp_count_reg != KP_SAT)) begin
        kp_count_next = kp_count_reg + 11'd1;
      end
      kp_drop_next = kp_drop_reg | drop_evt;
    end
  end

  // Frame statistics registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      kp_count_reg <= '0;
      kp_drop_reg  <= 1'b0;
    end else begin
      kp_count_reg <= kp_count_next;
      kp_drop_reg  <= kp_drop_next;
    end
  end

  assign o_frame_done = frame_done;
  assign o_kp_count   = kp_count_reg;
  assign o_kp_drop    = kp_drop_reg;

endmodule

// File: tb/tb_fast_kp_sched.sv
// Testbench for fast_kp_sched: directed windows, an emulated fixed-latency
// datapath, and a queue-based reference model compared every cycle.
`timescale 1ns/1ps
module tb_fast_kp_sched;
  localparam int L  = 6;
  localparam int D  = 8;
  localparam int CW = 10;
`ifdef FAST_KP_CAP_EN
  localparam int MAXK  = 3;
  localparam bit CAPON = 1'b1;
`else
  localparam int MAXK  = 1023;
  localparam bit CAPON = 1'b0;
`endif
  localparam int CAPLIM = CAPON ? MAXK : (1 << 20);

  logic          clk;
  logic          i_rst;
  logic          i_win_valid;
  logic          o_win_ready;
  logic [CW-1:0] i_win_x;
  logic [CW-1:0] i_win_y;
  logic          i_win_last;
  logic          i_dp_flag;
  logic [7:0]    i_dp_score;
  logic          o_kp_valid;
  logic          i_kp_ready;
  logic [CW-1:0] o_kp_x;
  logic [CW-1:0] o_kp_y;
  logic [7:0]    o_kp_score;
  logic          o_frame_done;
  logic [10:0]   o_kp_count;
  logic          o_kp_drop;

  fast_kp_sched #(.LATENCY(L), .DEPTH(D), .COORD_W(CW), .MAX_KP(MAXK)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_win_valid(i_win_valid), .o_win_ready(o_win_ready),
    .i_win_x(i_win_x), .i_win_y(i_win_y), .i_win_last(i_win_last),
    .i_dp_flag(i_dp_flag), .i_dp_score(i_dp_score),
    .o_kp_valid(o_kp_valid), .i_kp_ready(i_kp_ready),
    .o_kp_x(o_kp_x), .o_kp_y(o_kp_y), .o_kp_score(o_kp_score),
    .o_frame_done(o_frame_done), .o_kp_count(o_kp_count), .o_kp_drop(o_kp_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int            exitc;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;
  } pend_t;
  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [7:0]    s;
  } kp_t;

  pend_t pq[$];
  kp_t   kq[$];
  int    m_count = 0;
  bit    m_drop  = 0;
  int    cyc     = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_pop   = 0;
  bit    dp_acc[4096];
  bit    dp_f[4096];
  logic [7:0] dp_s[4096];
  logic       w_flag;
  logic [7:0] w_score;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit model_ready();
    return (i_rst == 1'b0) && ((kq.size() + pq.size()) < D);
  endfunction

  // Per-cycle compare against the model, then advance the model one cycle
  pend_t m_e;
  bit    m_fd, m_push, m_dropev, m_acc;
  always @(negedge clk) begin
    m_fd = (pq.size() > 0) && (pq[0].exitc == cyc) && pq[0].last;
    chk("win_ready", 32'(o_win_ready), 32'(model_ready()));
    chk("kp_valid", 32'(o_kp_valid), 32'(kq.size() > 0));
    if (kq.size() > 0) begin
      chk("kp_x", 32'(o_kp_x), 32'(kq[0].x));
      chk("kp_y", 32'(o_kp_y), 32'(kq[0].y));
      chk("kp_score", 32'(o_kp_score), 32'(kq[0].s));
    end
    chk("frame_done", 32'(o_frame_done), 32'(m_fd));
    chk("kp_count", 32'(o_kp_count), 32'(m_count));
    chk("kp_drop", 32'(o_kp_drop), 32'(m_drop));

    m_acc = i_win_valid && model_ready();
    dp_acc[cyc % 4096] = m_acc;
    dp_f[cyc % 4096]   = w_flag;
    dp_s[cyc % 4096]   = w_score;

    if (i_rst) begin
      pq.delete();
      kq.delete();
      m_count = 0;
      m_drop  = 0;
    end else begin
      if ((kq.size() > 0) && i_kp_ready) begin
        void'(kq.pop_front());
        n_pop++;
      end
      m_push = 0;
      m_dropev = 0;
      if ((pq.size() > 0) && (pq[0].exitc == cyc)) begin
        m_e = pq.pop_front();
        if (i_dp_flag) begin
          if (!CAPON || (m_count < MAXK)) m_push = 1;
          else m_dropev = 1;
        end
        if (m_push) kq.push_back('{m_e.x, m_e.y, i_dp_score});
      end
      if (m_fd) begin
        m_count = m_push ? 1 : 0;
        m_drop  = m_dropev;
      end else begin
        if (m_push && (m_count < 2047)) m_count++;
        m_drop = m_drop | m_dropev;
      end
      if (m_acc) pq.push_back('{cyc + L, i_win_x, i_win_y, i_win_last});
    end
    cyc++;
  end

  // Datapath emulation: result of the window sampled L cycles ago, or a
  // flagged garbage result when no window is due (must be ignored)
  initial begin
    i_dp_flag  = 1'b0;
    i_dp_score = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if ((cyc >= L) && dp_acc[(cyc - L) % 4096]) begin
        i_dp_flag  = dp_f[(cyc - L) % 4096];
        i_dp_score = dp_s[(cyc - L) % 4096];
      end else begin
        i_dp_flag  = 1'b1;
        i_dp_score = 8'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_win_valid = 1'b0;
    tick();
    i_rst = 1'b0;
  endtask

  // Present one window until accepted (bounded); ac = acceptance cycle
  task automatic send(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic last,
                      input logic flag, input logic [7:0] s, output int ac);
    int n;
    n = 0;
    i_win_valid = 1'b1;
    i_win_x = x;
    i_win_y = y;
    i_win_last = last;
    w_flag = flag;
    w_score = s;
    while (!model_ready() && (n < 200)) begin
      tick();
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 0);
    ac = cyc;
    tick();
    i_win_valid = 1'b0;
    i_win_last = 1'b0;
  endtask

  initial begin
    int a0, k, p0, cs;
    bit seen;
    i_rst = 1'b1; i_win_valid = 1'b0; i_win_x = '0; i_win_y = '0;
    i_win_last = 1'b0; i_kp_ready = 1'b0; w_flag = 1'b0; w_score = 8'd0;
    tick();
    tick();
    chk("rst_win_ready", 32'(o_win_ready), 0);
    i_rst = 1'b0;
    tick();
    chk("init_kp_valid", 32'(o_kp_valid), 0);
    chk("init_kp_x", 32'(o_kp_x), 0);
    chk("init_kp_count", 32'(o_kp_count), 0);
    chk("init_kp_drop", 32'(o_kp_drop), 0);
    chk("init_win_ready", 32'(o_win_ready), 1);

    // Single window, result visible LATENCY+1 cycles after accept
    repeat (3) tick();
    send(10'd5, 10'd7, 1'b0, 1'b1, 8'd42, a0);
    wait_until(a0 + L);
    chk("t1_not_yet", 32'(o_kp_valid), 0);
    tick();
    chk("t1_valid", 32'(o_kp_valid), 1);
    chk("t1_x", 32'(o_kp_x), 5);
    chk("t1_y", 32'(o_kp_y), 7);
    chk("t1_score", 32'(o_kp_score), 42);
    chk("t1_count", 32'(o_kp_count), 1);
    i_kp_ready = 1'b1;
    repeat (2) tick();

    // Back-pressure: credits stop admission at DEPTH, then drain in order
    do_reset();
    i_kp_ready = 1'b0;
    k = 0;
    for (int n = 0; n < 20; n++) begin
      i_win_valid = 1'b1;
      i_win_x = CW'(100 + k);
      i_win_y = CW'(50 + k);
      i_win_last = 1'b0;
      w_flag = 1'b1;
      w_score = 8'(100 + k);
      if (model_ready()) k++;
      tick();
    end
    i_win_valid = 1'b0;
`ifndef FAST_KP_CAP_EN
    chk("t2_accepts", 32'(k), 8);
    chk("t2_ready_low", 32'(o_win_ready), 0);
`endif
    chk("t2_head_x", 32'(o_kp_x), 100);
    p0 = n_pop;
    i_kp_ready = 1'b1;
    repeat (12) tick();
    chk("t2_drained", 32'(n_pop - p0), 32'(imin(8, CAPLIM)));

    // Alternating flags at full rate with the sink always ready
    do_reset();
    i_kp_ready = 1'b1;
    p0 = n_pop;
    cs = cyc;
    for (int n = 0; n < 12; n++)
      send(CW'(200 + n), CW'(20 + n), 1'b0, (n % 2) == 0, 8'(n + 1), a0);
    chk("t3_cycles", 32'(cyc - cs), 12);
    repeat (L + 4) tick();
    chk("t3_popped", 32'(n_pop - p0), 32'(imin(6, CAPLIM)));
    chk("t3_count", 32'(o_kp_count), 32'(imin(6, CAPLIM)));

    // Frame end on the 4th window
    do_reset();
    for (int n = 0; n < 4; n++)
      send(CW'(400 + n), CW'(40 + n), n == 3, n != 3, 8'(60 + n), a0);
    wait_until(a0 + L);
    chk("t4_frame_done", 32'(o_frame_done), 1);
    chk("t4_count_before", 32'(o_kp_count), 3);
    tick();
    chk("t4_frame_done_low", 32'(o_frame_done), 0);
    chk("t4_count_after", 32'(o_kp_count), 0);
    chk("t4_drop_after", 32'(o_kp_drop), 0);

    // Five flagged windows: capped build keeps MAX_KP and flags the drop
    do_reset();
    for (int n = 0; n < 5; n++)
      send(CW'(500 + n), CW'(60 + n), 1'b0, 1'b1, 8'(200 + n), a0);
    repeat (L + 3) tick();
    chk("t5_count", 32'(o_kp_count), 32'(imin(5, CAPLIM)));
    chk("t5_drop", 32'(o_kp_drop), 32'(CAPON && (MAXK < 5)));

    // Reset with 2 queued and 4 in flight
    do_reset();
    i_kp_ready = 1'b0;
    for (int n = 0; n < 2; n++)
      send(CW'(300 + n), CW'(30 + n), 1'b0, 1'b1, 8'(30 + n), a0);
    repeat (L + 2) tick();
    chk("t6_queued", 32'(o_kp_valid), 1);
    for (int n = 0; n < 4; n++)
      send(CW'(310 + n), CW'(31 + n), 1'b0, 1'b1, 8'(40 + n), a0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("t6_valid", 32'(o_kp_valid), 0);
    chk("t6_x", 32'(o_kp_x), 0);
    chk("t6_y", 32'(o_kp_y), 0);
    chk("t6_score", 32'(o_kp_score), 0);
    chk("t6_frame_done", 32'(o_frame_done), 0);
    chk("t6_count", 32'(o_kp_count), 0);
    chk("t6_drop", 32'(o_kp_drop), 0);
    i_kp_ready = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      tick();
      seen = seen | o_kp_valid;
    end
    chk("t6_no_kp_after_rst", 32'(seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fast_kp_sched.md
# fast_kp_sched

Issue scheduler and result collector for the FAST-9 corner datapath. The datapath has a fixed 6-cycle latency and no valid or stall signals of its own, so this block does the sequencing. It admits candidate windows from the window generator under a credit rule, tags each admitted window with its coordinates through a 6-deep shadow pipeline, and captures flagged results into a keypoint FIFO. The FIFO feeds the downstream orientation/descriptor stage over a valid/ready handshake.

## Interface
- LATENCY, 6, datapath latency in cycles from window sample to flag/score; must be at least 1.
- DEPTH, 8, keypoint FIFO depth; power of two, at least 2.
- COORD_W, 10, width of the x and y coordinates.
- MAX_KP, 1023, per-frame keypoint cap; used only when FAST_KP_CAP_EN is defined.

Ports:
- i_clk, in, 1, single clock; all logic on the rising edge.
- i_rst, in, 1, synchronous, active-high reset.
- i_win_valid, in, 1, candidate window present (pixels go straight to the datapath).
- o_win_ready, out, 1, window accepted this cycle when high together with i_win_valid.
- i_win_x, in, COORD_W, window centre x.
- i_win_y, in, COORD_W, window centre y.
- i_win_last, in, 1, last window of the frame.
- i_dp_flag, in, 1, datapath keypoint flag.
- i_dp_score, in, 8, datapath score.
- o_kp_valid, out, 1, FIFO head is valid.
- i_kp_ready, in, 1, downstream accepts the head.
- o_kp_x, out, COORD_W, keypoint x.
- o_kp_y, out, COORD_W, keypoint y.
- o_kp_score, out, 8, keypoint score.
- o_frame_done, out, 1, one-cycle pulse when the last-tagged window leaves the shadow pipeline.
- o_kp_count, out, 11, keypoints captured in the current frame.
- o_kp_drop, out, 1, sticky: a keypoint was discarded in the current frame.

## Operation
- Accept is defined as i_win_valid & o_win_ready.
- o_win_ready = !i_rst & (fifo_count + inflight < DEPTH).
  - inflight is the number of valid slots in the shadow pipeline.
  - The rule is conservative: every in-flight window is counted as a possible keypoint, so the FIFO can never overflow.
- Shadow pipeline:
  - LATENCY stages, each holding {valid, x, y, last}.
  - Stage 0 loads the window fields on accept, or valid=0 otherwise.
  - The pipeline shifts every cycle unconditionally, in lockstep with the datapath.
- Exit stage (stage LATENCY-1 valid):
  - If i_dp_flag=1, push {x, y, i_dp_score} into the FIFO. Under FAST_KP_CAP_EN the push is further gated by the cap.
  - If last=1, pulse o_frame_done.
- FIFO behaviour:
  - Pop occurs on o_kp_valid & i_kp_ready.
  - Push and pop in the same cycle are both performed; fifo_count is unchanged.
  - Pointers wrap modulo DEPTH.
  - The head fields are registered-read and stable while o_kp_valid=1 and i_kp_ready=0.
- inflight is updated each cycle as +accept − (exit-stage valid); a simultaneous accept and exit leaves it unchanged.
- o_kp_count:
  - Saturates at 2047.
  - On the cycle after o_frame_done it clears to 0, and o_kp_drop clears with it.
  - A push in that same cycle counts as 1.
- Reset mid-frame:
  - All in-flight tags and all FIFO contents are discarded.
  - Datapath outputs arriving after reset are ignored, because the tags are invalid.
- No state machine: control is credit- and tag-driven.

## Timing
- Window accepted in cycle t → its datapath result is sampled at the end of cycle t+LATENCY → keypoint is visible on o_kp_valid in cycle t+LATENCY+1.
- o_frame_done is asserted in cycle t+LATENCY for a last window accepted in cycle t.
- Reset values: o_kp_valid=0, o_kp_x/y/score=0, o_frame_done=0, o_kp_count=0, o_kp_drop=0, o_win_ready=0 while i_rst=1.
- Throughput: one window per cycle while credits remain. With i_kp_ready held high, steady state is 1/cycle, because the pop frees a credit in the same cycle it is counted.

## Configuration
- FAST_KP_CAP_EN defined:
  - A keypoint is pushed only while o_kp_count < MAX_KP.
  - A flagged exit at the cap is discarded and sets o_kp_drop.
- FAST_KP_CAP_EN undefined:
  - All flagged exits are pushed.
  - o_kp_drop is tied to 0.
  - o_kp_count still counts.

## Test plan
- Single window (x=5, y=7) accepted at cycle 10, i_dp_flag=1 and score=42 at cycle 16 → o_kp_valid in cycle 17 with 5/7/42, o_kp_count=1.
- i_kp_ready=0, continuous windows, all flagged → exactly DEPTH=8 accepts, then o_win_ready=0. Raising i_kp_ready drains 8 entries in order with no loss.
- Flagged and unflagged exits alternating, i_kp_ready=1 → only flagged entries appear, in order, at 1 accept per cycle.
- i_win_last on the 4th window → o_frame_done pulses LATENCY cycles later; o_kp_count and o_kp_drop are 0 one cycle after the pulse.
- FAST_KP_CAP_EN with MAX_KP=3, 5 flagged windows → 3 pushed, o_kp_drop=1, o_kp_count=3.
- i_rst asserted with 4 in-flight windows and 2 queued → all outputs 0 next cycle; no keypoints appear after release despite flagged datapath outputs.
